dbg_loader: RTL and testbench

- Byte-stream debug loader sitting directly upstream of the core top level.
- Drives the core's CPU_RST input and its InstRAM/DataRAM debug ports (A2/WD2/WE2/RD2).
- Accepts framed commands from a host byte link (e.g. a UART RX/TX pair), loads or reads back memory words, and holds or releases the core from reset.

---
 rtl/dbg_loader.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_dbg_loader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_loader.sv
// dbg_loader: byte-stream debug loader placed in front of the core top level.
//
// A host byte link delivers framed commands. The loader uses them to write or
// read back words in the core's InstRAM/DataRAM debug ports, and to hold the
// core in reset or release it. Each command is answered with ACK_BYTE, or with
// NAK_BYTE when the opcode is unknown.
//
// Frame layout:
//   opcode
//   addr[7:0] addr[15:8] addr[23:16] addr[31:24]
//   cnt[7:0] cnt[15:8]
//   for writes only: cnt words, each sent LSB first
//
// Opcodes:
//   0x01 write InstRAM   0x02 write DataRAM
//   0x03 read InstRAM    0x04 read DataRAM
//   0x05 RUN (release the core)   0x06 HALT (hold the core in reset)
//
// Handshake: a byte moves on rx (or tx) in any cycle where valid and ready are
// both high at the rising clock edge. The producer holds data stable while
// valid is high and ready is low, and does not withdraw valid before the
// transfer.
//
// Ports:
//   clk, rst_n                    clock; asynchronous active-low reset
//   rx_data_i/rx_valid_i/rx_ready_o   command bytes from the host
//   tx_data_o/tx_valid_o/tx_ready_i   response bytes to the host
//   cpu_rst_o                     core CPU_RST (active-high)
//   inst_a2_o/wd2_o/we2_o/rd2_i   InstRAM debug port (read latency 1 cycle)
//   data_a2_o/wd2_o/we2_o/rd2_i   DataRAM debug port (read latency 1 cycle)
//   busy_o                        high whenever the FSM is not idle
module dbg_loader #(
  parameter logic [7:0]  ACK_BYTE  = 8'hAA,
  parameter logic [7:0]  NAK_BYTE  = 8'hEE,
  parameter int unsigned MAX_WORDS = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        cpu_rst_o,
  output logic [31:0] inst_a2_o,
  output logic [31:0] inst_wd2_o,
  output logic [3:0]  inst_we2_o,
  input  logic [31:0] inst_rd2_i,
  output logic [31:0] data_a2_o,
  output logic [31:0] data_wd2_o,
  output logic [3:0]  data_we2_o,
  input  logic [31:0] data_rd2_i,
  output logic        busy_o
);

  // The count field is 16 bits on the wire, so this evaluates to 16.
  localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_ADDR  = 4'd1,
    S_CNT   = 4'd2,
    S_WBYTE = 4'd3,
    S_WRITE = 4'd4,
    S_RREQ  = 4'd5,
    S_RWAIT = 4'd6,
    S_RSEND = 4'd7,
    S_RESP  = 4'd8
  } state_e;

  state_e             state_q,    state_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [31:0]        addr_q,     addr_d;
  logic [CNT_W-1:0]   count_q,    count_d;
  logic [31:0]        word_q,     word_d;
  logic               is_read_q,  is_read_d;
  logic               sel_data_q, sel_data_d;
  logic               cpu_rst_q,  cpu_rst_d;
  logic               rx_ready_q, rx_ready_d;
  logic [7:0]         tx_data_q,  tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic [31:0]        inst_a2_q,  inst_a2_d;
  logic [31:0]        inst_wd2_q, inst_wd2_d;
  logic [3:0]         inst_we2_q, inst_we2_d;
  logic [31:0]        data_a2_q,  data_a2_d;
  logic [31:0]        data_wd2_q, data_wd2_d;
  logic [3:0]         data_we2_q, data_we2_d;

  logic               rx_take;
  logic               tx_take;
  logic [31:0]        rd_word;
  logic [31:0]        addr_next;

  assign rx_take   = rx_valid_i & rx_ready_q;
  assign tx_take   = tx_valid_q & tx_ready_i;
  assign rd_word   = sel_data_q ? data_rd2_i : inst_rd2_i;
  assign addr_next = addr_q + 32'd4;  // wraps modulo 2^32 by width

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    count_d    = count_q;
    word_d     = word_q;
    is_read_d  = is_read_q;
    sel_data_d = sel_data_q;
    cpu_rst_d  = cpu_rst_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    inst_a2_d  = inst_a2_q;
    inst_wd2_d = inst_wd2_q;
    data_a2_d  = data_a2_q;
    data_wd2_d = data_wd2_q;
    // The write strobes last one cycle; they are raised only on the way
    // into WRITE.
    inst_we2_d = 4'h0;
    data_we2_d = 4'h0;

    case (state_q)
      S_IDLE: begin
        if (rx_take) begin
          byte_cnt_d = 2'd0;
          case (rx_data_i)
            8'h01, 8'h02: begin
              // Loading memory always stops the core first.
              cpu_rst_d  = 1'b1;
              is_read_d  = 1'b0;
              sel_data_d = (rx_data_i == 8'h02);
              state_d    = S_ADDR;
            end
            8'h03, 8'h04: begin
              is_read_d  = 1'b1;
              sel_data_d = (rx_data_i == 8'h04);
              state_d    = S_ADDR;
            end
            8'h05: begin
              cpu_rst_d  = 1'b0;
              tx_data_d  = ACK_BYTE;
              tx_valid_d = 1'b1;
              state_d    = S_RESP;
            end
            8'h06: begin
              cpu_rst_d  = 1'b1;
              tx_data_d  = ACK_BYTE;
              tx_valid_d = 1'b1;
              state_d    = S_RESP;
            end
            default: begin
              tx_data_d  = NAK_BYTE;
              tx_valid_d = 1'b1;
              state_d    = S_RESP;
            end
          endcase
        end
      end

      S_ADDR: begin
        if (rx_take) begin
          // Bytes arrive LSB first: shift each one in from the top.
          addr_d     = {rx_data_i, addr_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            addr_d[1:0] = 2'b00;  // word-aligned accesses only
            byte_cnt_d  = 2'd0;
            state_d     = S_CNT;
          end
        end
      end

      S_CNT: begin
        if (rx_take) begin
          count_d    = {rx_data_i, count_q[CNT_W-1:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd1) begin
            byte_cnt_d = 2'd0;
            if (count_d == '0) begin
              tx_data_d  = ACK_BYTE;
              tx_valid_d = 1'b1;
              state_d    = S_RESP;
            end else if (is_read_q) begin
              if (sel_data_q) data_a2_d = addr_q;
              else            inst_a2_d = addr_q;
              state_d = S_RREQ;
            end else begin
              state_d = S_WBYTE;
            end
          end
        end
      end

      S_WBYTE: begin
        if (rx_take) begin
          word_d     = {rx_data_i, word_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = 2'd0;
            state_d    = S_WRITE;
            // Set up the strobe so that it is high exactly while in WRITE.
            if (sel_data_q) begin
              data_we2_d = 4'hF;
              data_a2_d  = addr_q;
              data_wd2_d = word_d;
            end else begin
              inst_we2_d = 4'hF;
              inst_a2_d  = addr_q;
              inst_wd2_d = word_d;
            end
          end
        end
      end

      S_WRITE: begin
        addr_d  = addr_next;
        count_d = count_q - 1'b1;
        if (count_q == CNT_W'(1)) begin
          tx_data_d  = ACK_BYTE;
          tx_valid_d = 1'b1;
          state_d    = S_RESP;
        end else begin
          state_d = S_WBYTE;
        end
      end

      // The address is presented during RREQ, and the RAM registers it on
      // that edge.
      S_RREQ: state_d = S_RWAIT;

      S_RWAIT: begin
        word_d     = rd_word;
        tx_data_d  = rd_word[7:0];
        tx_valid_d = 1'b1;
        byte_cnt_d = 2'd0;
        state_d    = S_RSEND;
      end

      S_RSEND: begin
        if (tx_take) begin
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = 2'd0;
            addr_d     = addr_next;
            count_d    = count_q - 1'b1;
            if (count_q == CNT_W'(1)) begin
              tx_data_d = ACK_BYTE;  // tx_valid stays high into RESP
              state_d   = S_RESP;
            end else begin
              tx_valid_d = 1'b0;
              if (sel_data_q) data_a2_d = addr_next;
              else            inst_a2_d = addr_next;
              state_d = S_RREQ;
            end
          end else begin
            word_d     = {8'h00, word_q[31:8]};
            tx_data_d  = word_q[15:8];
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

      S_RESP: begin
        if (tx_take) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // rx_ready is registered from the next state. This keeps it low during
    // reset, and it matches the current state at all other times.
    rx_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) ||
                 (state_d == S_CNT)  || (state_d == S_WBYTE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      addr_q     <= 32'h0;
      count_q    <= '0;
      word_q     <= 32'h0;
      is_read_q  <= 1'b0;
      sel_data_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
      rx_ready_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      inst_a2_q  <= 32'h0;
      inst_wd2_q <= 32'h0;
      inst_we2_q <= 4'h0;
      data_a2_q  <= 32'h0;
      data_wd2_q <= 32'h0;
      data_we2_q <= 4'h0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      word_q     <= word_d;
      is_read_q  <= is_read_d;
      sel_data_q <= sel_data_d;
      cpu_rst_q  <= cpu_rst_d;
      rx_ready_q <= rx_ready_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      inst_a2_q  <= inst_a2_d;
      inst_wd2_q <= inst_wd2_d;
      inst_we2_q <= inst_we2_d;
      data_a2_q  <= data_a2_d;
      data_wd2_q <= data_wd2_d;
      data_we2_q <= data_we2_d;
    end
  end

  assign rx_ready_o = rx_ready_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign cpu_rst_o  = cpu_rst_q;
  assign inst_a2_o  = inst_a2_q;
  assign inst_wd2_o = inst_wd2_q;
  assign inst_we2_o = inst_we2_q;
  assign data_a2_o  = data_a2_q;
  assign data_wd2_o = data_wd2_q;
  assign data_we2_o = data_we2_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_dbg_loader.sv
// Testbench for dbg_loader. The design drives two behavioural synchronous RAMs
// (read latency 1). The expected values come from reference memories that the
// bench updates directly from frame contents.
module tb_dbg_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        cpu_rst_o;
  logic [31:0] inst_a2_o, inst_wd2_o, inst_rd2_i;
  logic [3:0]  inst_we2_o;
  logic [31:0] data_a2_o, data_wd2_o, data_rd2_i;
  logic [3:0]  data_we2_o;
  logic        busy_o;

  localparam logic [7:0] ACK = 8'hAA;
  localparam logic [7:0] NAK = 8'hEE;

  int checks = 0;
  int errors = 0;

  // Expected write: {sel_data, addr, data}
  logic [64:0] exp_q[$];
  logic [31:0] ref_imem[logic [31:0]];
  logic [31:0] ref_dmem[logic [31:0]];
  logic [31:0] ram_i[logic [31:0]];
  logic [31:0] ram_d[logic [31:0]];
  logic [31:0] wbuf[16];
  logic        exp_rst;

  dbg_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .cpu_rst_o  (cpu_rst_o),
    .inst_a2_o  (inst_a2_o),
    .inst_wd2_o (inst_wd2_o),
    .inst_we2_o (inst_we2_o),
    .inst_rd2_i (inst_rd2_i),
    .data_a2_o  (data_a2_o),
    .data_wd2_o (data_wd2_o),
    .data_we2_o (data_we2_o),
    .data_rd2_i (data_rd2_i),
    .busy_o     (busy_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural RAMs ----------------
  always @(posedge clk) begin
    logic [31:0] ri, rd;
    ri = ram_i.exists(inst_a2_o) ? ram_i[inst_a2_o] : 32'h0;
    rd = ram_d.exists(data_a2_o) ? ram_d[data_a2_o] : 32'h0;
    if (inst_we2_o == 4'hF) ram_i[inst_a2_o] = inst_wd2_o;
    if (data_we2_o == 4'hF) ram_d[data_a2_o] = data_wd2_o;
    inst_rd2_i <= ri;
    data_rd2_i <= rd;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input bit sel, input logic [31:0] a);
    if (sel) return ref_dmem.exists(a) ? ref_dmem[a] : 32'h0;
    return ref_imem.exists(a) ? ref_imem[a] : 32'h0;
  endfunction

  // Advance to the next falling edge, then check any write strobe that is
  // visible against the scoreboard.
  task automatic tick();
    logic [64:0] e;
    @(negedge clk);
    if (inst_we2_o !== 4'h0 || data_we2_o !== 4'h0) begin
      if (exp_q.size() == 0) begin
        chk("spurious_we2", 64'({inst_we2_o, data_we2_o}), 64'h0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_we2_pair", 64'({inst_we2_o, data_we2_o}), e[64] ? 64'h0F : 64'hF0);
        chk("wr_a2", 64'(e[64] ? data_a2_o : inst_a2_o), 64'(e[63:32]));
        chk("wr_wd2", 64'(e[64] ? data_wd2_o : inst_wd2_o), 64'(e[31:0]));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int gap;
    int w;
    gap = $urandom_range(0, 2);
    w = 0;
    for (int i = 0; i < gap; i++) tick();
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    while (rx_ready_o !== 1'b1 && w < 200) begin
      tick();
      w++;
    end
    if (w >= 200) chk("rx_ready_timeout", 64'(rx_ready_o), 64'h1);
    tick();
    rx_valid_i = 1'b0;
    rx_data_i  = 8'($urandom);
  endtask

  task automatic recv_byte(input logic [7:0] exp, input string tag, input bit throttle);
    int w;
    bit r;
    logic [7:0] held;
    w = 0;
    while (tx_valid_o !== 1'b1 && w < 200) begin
      tick();
      w++;
    end
    chk({tag, "_valid"}, 64'(tx_valid_o), 64'h1);
    chk({tag, "_data"}, 64'(tx_data_o), 64'(exp));
    chk({tag, "_rx_ready_low"}, 64'(rx_ready_o), 64'h0);
    held = tx_data_o;
    for (int k = 0; k < 50; k++) begin
      r = !throttle || ($urandom_range(0, 2) == 0) || (k == 49);
      tx_ready_i = r;
      tick();
      if (r) break;
      chk({tag, "_hold"}, 64'({tx_valid_o, tx_data_o}), 64'({1'b1, held}));
    end
    tx_ready_i = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [31:0] addr, input int n);
    logic [15:0] c;
    c = 16'(n);
    send_byte(op);
    if (op == 8'h01 || op == 8'h02) chk("cpu_rst_after_wr_op", 64'(cpu_rst_o), 64'h1);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    send_byte(c[7:0]);
    send_byte(c[15:8]);
  endtask

  task automatic do_write(input bit sel, input logic [31:0] addr, input int n);
    logic [31:0] a;
    a = addr & 32'hFFFF_FFFC;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({sel, a, wbuf[i]});
      if (sel) ref_dmem[a] = wbuf[i];
      else     ref_imem[a] = wbuf[i];
      a = a + 32'd4;
    end
    send_hdr(sel ? 8'h02 : 8'h01, addr, n);
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 4; b++) send_byte(wbuf[i][8*b +: 8]);
    recv_byte(ACK, "wr_ack", 1'b0);
    chk("wr_all_seen", 64'(exp_q.size()), 64'h0);
    exp_rst = 1'b1;
  endtask

  task automatic do_read(input bit sel, input logic [31:0] addr, input int n, input bit throttle);
    logic [31:0] a;
    logic [31:0] e;
    a = addr & 32'hFFFF_FFFC;
    send_hdr(sel ? 8'h04 : 8'h03, addr, n);
    for (int i = 0; i < n; i++) begin
      e = ref_rd(sel, a);
      for (int b = 0; b < 4; b++) recv_byte(e[8*b +: 8], "rd_byte", throttle);
      a = a + 32'd4;
    end
    recv_byte(ACK, "rd_ack", throttle);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] op;
    int kind;
    rst_n      = 1'b0;
    rx_data_i  = 8'h00;
    rx_valid_i = 1'b0;
    tx_ready_i = 1'b0;
    exp_rst    = 1'b1;

    // Reset values while reset is held
    repeat (3) tick();
    chk("rst_cpu_rst", 64'(cpu_rst_o), 64'h1);
    chk("rst_rx_ready", 64'(rx_ready_o), 64'h0);
    chk("rst_tx_valid", 64'(tx_valid_o), 64'h0);
    chk("rst_tx_data", 64'(tx_data_o), 64'h0);
    chk("rst_busy", 64'(busy_o), 64'h0);
    chk("rst_addr_wd", 64'({inst_a2_o, data_a2_o}) | 64'({inst_wd2_o, data_wd2_o}), 64'h0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("idle_cpu_rst", 64'(cpu_rst_o), 64'h1);
    chk("idle_we2", 64'({inst_we2_o, data_we2_o}), 64'h0);
    chk("idle_tx_valid", 64'(tx_valid_o), 64'h0);
    chk("idle_rx_ready", 64'(rx_ready_o), 64'h1);

    // Two InstRAM words at address 0
    wbuf[0] = 32'hDEADBEEF;
    wbuf[1] = 32'h12345678;
    do_write(1'b0, 32'h0, 2);
    do_read(1'b0, 32'h0, 2, 1'b0);

    // DataRAM readback with a throttled host
    wbuf[0] = 32'hCAFEF00D;
    do_write(1'b1, 32'h10, 1);
    do_read(1'b1, 32'h10, 1, 1'b1);

    // RUN, a read leaves the core running, HALT, unknown opcode
    send_byte(8'h05);
    recv_byte(ACK, "run_ack", 1'b0);
    chk("run_cpu_rst", 64'(cpu_rst_o), 64'h0);
    do_read(1'b1, 32'h10, 1, 1'b0);
    chk("read_keeps_cpu_rst", 64'(cpu_rst_o), 64'h0);
    send_byte(8'h06);
    recv_byte(ACK, "halt_ack", 1'b0);
    chk("halt_cpu_rst", 64'(cpu_rst_o), 64'h1);
    send_byte(8'h7F);
    recv_byte(NAK, "nak", 1'b0);
    chk("nak_no_write", 64'(exp_q.size()), 64'h0);

    // A write that starts after RUN puts the core back into reset.
    send_byte(8'h05);
    recv_byte(ACK, "run2_ack", 1'b0);
    wbuf[0] = 32'h0BADC0DE;
    do_write(1'b0, 32'h20, 1);

    // Address wrap, and address bits [1:0] forced to zero
    wbuf[0] = 32'h11223344;
    wbuf[1] = 32'h55667788;
    do_write(1'b1, 32'hFFFF_FFFF, 2);
    do_read(1'b1, 32'hFFFF_FFFC, 2, 1'b1);
    wbuf[0] = 32'hA5A5_5A5A;
    do_write(1'b0, 32'h13, 1);
    do_read(1'b0, 32'h10, 1, 1'b0);

    // Zero-count frames
    do_write(1'b1, 32'h80, 0);
    do_read(1'b0, 32'h80, 0, 1'b0);

    // Reset asserted partway through the second data word
    wbuf[0] = 32'h01020304;
    wbuf[1] = 32'hF0E0D0C0;
    exp_q.push_back({1'b0, 32'h40, wbuf[0]});
    ref_imem[32'h40] = wbuf[0];
    send_hdr(8'h01, 32'h40, 2);
    for (int b = 0; b < 4; b++) send_byte(wbuf[0][8*b +: 8]);
    send_byte(wbuf[1][7:0]);
    send_byte(wbuf[1][15:8]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_cpu_rst", 64'(cpu_rst_o), 64'h1);
    chk("midrst_we2", 64'({inst_we2_o, data_we2_o}), 64'h0);
    chk("midrst_busy", 64'(busy_o), 64'h0);
    chk("midrst_rx_ready", 64'(rx_ready_o), 64'h0);
    chk("midrst_tx_valid", 64'(tx_valid_o), 64'h0);
    chk("midrst_a2", 64'({inst_a2_o, data_a2_o}), 64'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("midrst_first_word_written", 64'(exp_q.size()), 64'h0);
    chk("post_rst_idle_ready", 64'(rx_ready_o), 64'h1);
    chk("post_rst_busy", 64'(busy_o), 64'h0);
    exp_rst = 1'b1;
    wbuf[0] = 32'h99887766;
    do_write(1'b0, 32'h48, 1);
    do_read(1'b0, 32'h40, 3, 1'b1);

    // Random mix of frames against the reference model
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1: begin
          for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
          do_write(1'($urandom_range(0, 1)), 32'h200 + 32'($urandom_range(0, 31)),
                   $urandom_range(0, 3));
        end
        2, 3: do_read(1'($urandom_range(0, 1)), 32'h200 + 32'($urandom_range(0, 31)),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        4: begin
          op = ($urandom_range(0, 1) == 0) ? 8'h05 : 8'h06;
          send_byte(op);
          recv_byte(ACK, "rnd_runhalt_ack", 1'($urandom_range(0, 1)));
          exp_rst = (op == 8'h06);
        end
        default: begin
          op = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(7, 255));
          send_byte(op);
          recv_byte(NAK, "rnd_nak", 1'b0);
        end
      endcase
      chk("rnd_cpu_rst", 64'(cpu_rst_o), 64'(exp_rst));
      chk("rnd_no_pending_writes", 64'(exp_q.size()), 64'h0);
    end

    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
